cpu_clock_controller: RTL and testbench
=======================================

// Module: cpu_clock_controller
// PURPOSE
//   Sequences the 8-bit CPU datapath by generating its single-cycle clock-enable (cpu_tick) from the
//   100MHz board clock. Modes: free-running at a DIP-selected rate, or manual single-step from a button.
//   A CPU halt request freezes ticking until reset. Sits between the pull-down-emulated DIP/button
//   inputs and every CPU register's enable.
// PARAMETERS
//   DEBOUNCE_CYCLES  500_000  cycles an input must differ from its debounced value before it is accepted (5ms @100MHz)
//   BASE_PERIOD      1000     run-mode tick period in clk cycles when rate_sel=0 (100kHz)
//   RATE_W           4        width of rate_sel; period = BASE_PERIOD << rate_sel
// PORTS
//   clk          in   1       100MHz system clock
//   rst          in   1       synchronous, active-high reset
//   run_sw       in   1       DIP: 1=free-run, 0=manual step (asynchronous to clk)
//   step_btn     in   1       step button, active high (asynchronous to clk)
//   rate_sel     in   RATE_W  DIP: run-mode rate select, 0=fastest
//   cpu_halt     in   1       CPU HLT control signal, synchronous to clk
//   cpu_tick     out  1       one-clk-wide enable; CPU state advances on clk edges where it is 1
//   clk_led      out  1       toggles on every cpu_tick (visible CPU clock phase)
//   running      out  1       1 while in S_RUN
//   halted       out  1       1 while in S_HALT
// BEHAVIOUR
//   - Reset: all outputs 0, state S_MANUAL, period counter 0, sync/debounce flops 0, debounce counters 0.
//   - run_sw, step_btn: 2-flop synchroniser each, then an independent debouncer each:
//     synced != debounced -> counter++; counter reaches DEBOUNCE_CYCLES-1 while still different ->
//     debounced <= synced, counter <= 0; synced == debounced -> counter <= 0.
//   - step_edge = debounced step rising edge (registered previous value); one request per press.
//   - FSM (all outputs registered):
//     S_MANUAL: step_edge -> cpu_tick=1 next cycle. run_db=1 -> S_RUN, period counter <= 0.
//     S_RUN: counter increments each cycle; when counter >= P-1 (P = BASE_PERIOD << rate_sel):
//       cpu_tick=1, counter <= 0. run_db=0 -> S_MANUAL, counter <= 0, no tick that cycle. step_edge ignored.
//     S_HALT: cpu_tick held 0; exited only by rst.
//   - cpu_halt=1 in any state -> S_HALT next cycle; halt beats a coincident tick (no tick issued).
//   - First run tick arrives P cycles after entering S_RUN; subsequent ticks every P cycles.
//   - rate_sel change mid-count: new P applies immediately; the >= compare means a counter already
//     past the new P-1 ticks on the next cycle, then wraps to 0 (no long wrap-around stall).
//   - Step latency: step_btn rising (held stable) -> cpu_tick high DEBOUNCE_CYCLES+4 clk edges later.
//   - Button release or bounce shorter than DEBOUNCE_CYCLES generates no tick.
//   - clk_led toggles the cycle after each cpu_tick is sampled; cleared by rst.
//   - Counter width = clog2(BASE_PERIOD << (2**RATE_W-1)); no overflow for any rate_sel.
//   - rst mid-operation (any state, mid-debounce, mid-period): all state returns to reset values next
//     cycle, no tick emitted on the reset cycle or the cycle after.
// TESTING (bench uses DEBOUNCE_CYCLES=4, BASE_PERIOD=4, RATE_W=4)
//   1. rst, run_sw=0, step_btn high for 20 cycles -> exactly one cpu_tick, 8 edges after press; clk_led=1.
//   2. step_btn pulses high for 2 cycles, 3 times -> no cpu_tick, clk_led stays 0.
//   3. run_sw=1, rate_sel=0 -> running=1; ticks every 4 cycles; rate_sel=2 -> ticks every 16 cycles.
//   4. run at rate_sel=3 (P=32), counter at 20, set rate_sel=0 -> tick next cycle, then every 4 cycles.
//   5. running, assert cpu_halt 1 cycle coincident with a due tick -> no tick, halted=1 held;
//      step presses and run_sw toggles produce no tick; rst -> halted=0, running=0.
//   6. rst asserted mid-debounce and mid-period -> all outputs 0; next tick needs a full fresh debounce/period.

Source files
------------

// File: rtl/cpu_clock_controller_if.sv
// Board/CPU-facing signal bundle for the CPU clock controller.
// master: the side driving switches/buttons/halt (board or bench).
// slave:  the controller itself.
interface cpu_clock_controller_if #(
  parameter int RATE_W = 4
);
  logic              run_sw;
  logic              step_btn;
  logic [RATE_W-1:0] rate_sel;
  logic              cpu_halt;
  logic              cpu_tick;
  logic              clk_led;
  logic              running;
  logic              halted;

  modport master (
    output run_sw, step_btn, rate_sel, cpu_halt,
    input  cpu_tick, clk_led, running, halted
  );

  modport slave (
    input  run_sw, step_btn, rate_sel, cpu_halt,
    output cpu_tick, clk_led, running, halted
  );
endinterface

// File: rtl/cpu_clock_controller.sv
// CPU clock-enable generator: free-run at BASE_PERIOD << rate_sel, or
// manual single-step from a debounced button; cpu_halt freezes until rst.
module cpu_clock_controller #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int BASE_PERIOD     = 1000,
  parameter int RATE_W          = 4
) (
  input logic                  clk,
  input logic                  rst,
  cpu_clock_controller_if.slave bus
);
  // Counter sized for the slowest rate so no rate_sel can overflow it.
  localparam int CNT_W = $clog2(BASE_PERIOD << (2**RATE_W - 1));
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  // Lane 0 = run_sw, lane 1 = step_btn.
  logic [1:0]            raw;
  logic [1:0]            sync1, sync2, db;
  logic [1:0][DB_W-1:0]  db_cnt;
  logic                  step_db_q, step_edge;

  typedef enum logic [1:0] {S_MANUAL, S_RUN, S_HALT} state_t;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W:0]       period_m1;
  logic                 tick_q, led_q, running_q, halted_q;

  assign raw = {bus.step_btn, bus.run_sw};

  // Synchronise each async input, then accept a new level only after it
  // has differed from the debounced value for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // One registered step request per debounced rising edge of the button.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_db_q <= 1'b0;
      step_edge <= 1'b0;
    end else begin
      step_db_q <= db[1];
      step_edge <= db[1] & ~step_db_q;
    end
  end

  // Rate change takes effect immediately; >= lets an overshot count fire next cycle.
  always_comb period_m1 = ((CNT_W+1)'(BASE_PERIOD) << bus.rate_sel) - (CNT_W+1)'(1);

  // Mode FSM with registered outputs; halt outranks any pending tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_MANUAL;
      cnt       <= '0;
      tick_q    <= 1'b0;
      led_q     <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      led_q  <= led_q ^ tick_q;
      tick_q <= 1'b0;
      if (bus.cpu_halt) begin
        state     <= S_HALT;
        cnt       <= '0;
        running_q <= 1'b0;
        halted_q  <= 1'b1;
      end else begin
        case (state)
          S_MANUAL: begin
            tick_q <= step_edge;
            if (db[0]) begin
              state     <= S_RUN;
              running_q <= 1'b1;
              cnt       <= '0;
            end
          end
          S_RUN: begin
            if (!db[0]) begin
              state     <= S_MANUAL;
              running_q <= 1'b0;
              cnt       <= '0;
            end else if ({1'b0, cnt} >= period_m1) begin
              tick_q <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_HALT: ;
          default: state <= S_MANUAL;
        endcase
      end
    end
  end

  assign bus.cpu_tick = tick_q;
  assign bus.clk_led  = led_q;
  assign bus.running  = running_q;
  assign bus.halted   = halted_q;
endmodule

// File: tb/tb_cpu_clock_controller.sv
// Scoreboard bench: stimulus pushes the cycle numbers at which cpu_tick is
// expected; a negedge monitor pops and compares every tick the DUT emits.
module tb_cpu_clock_controller;
  localparam int D  = 4;
  localparam int BP = 4;
  localparam int RW = 4;
  localparam int SYNC_LAT = 2;           // synchroniser flops
  localparam int RUN_LAT  = SYNC_LAT + D + 1; // run_sw change -> FSM reacts
  localparam int STEP_LAT = D + 4;       // step press -> cpu_tick

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_clock_controller_if #(.RATE_W(RW)) bus();

  cpu_clock_controller #(
    .DEBOUNCE_CYCLES(D), .BASE_PERIOD(BP), .RATE_W(RW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errs   = 0;
  int exp_q[$];
  int npush  = 0;   // ticks expected since last reset (clk_led parity)
  int anchor;       // cycle of last tick (or of entering run mode)
  int cur_p;

  // Monitor: every tick must match the oldest expected tick cycle.
  always @(negedge clk) begin
    int e;
    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      checks++; errs++;
      $display("FAIL missed_tick: no tick at cycle %0d (now %0d)", exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
    if (bus.cpu_tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          errs++;
          $display("FAIL tick_time: tick at cycle %0d, expected %0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic at(input int c);
    if (cyc > c) begin
      checks++; errs++;
      $display("FAIL schedule: asked for cycle %0d at cycle %0d", c, cyc);
    end
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input int e);
    exp_q.push_back(e);
    npush++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int per(input int r);
    return BP << r;
  endfunction

  // Rate change after edge c: next tick is whichever comes later of a full
  // new period from the last tick, or the very next edge.
  task automatic change_rate(input int nr, input int c);
    int nxt;
    at(c);
    bus.rate_sel = RW'(nr);
    cur_p = per(nr);
    nxt = anchor + cur_p;
    if (c + 1 > nxt) nxt = c + 1;
    push(nxt);
    anchor = nxt;
  endtask

  task automatic more_ticks(input int m);
    for (int i = 0; i < m; i++) begin
      anchor += cur_p;
      push(anchor);
    end
  endtask

  task automatic enter_run(input int r);
    bus.rate_sel = RW'(r);
    cur_p = per(r);
    bus.run_sw = 1'b1;
    anchor = cyc + RUN_LAT;
    at(anchor);
    chk("running_on_entry", bus.running, 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tick"},    bus.cpu_tick, 0);
    chk({tag, "_led"},     bus.clk_led,  0);
    chk({tag, "_running"}, bus.running,  0);
    chk({tag, "_halted"},  bus.halted,   0);
  endtask

  initial begin
    int n, h, w, c, t;
    bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.rate_sel = '0; bus.cpu_halt = 1'b0;

    // Reset state
    at(3);
    check_idle("reset");
    rst = 1'b0;

    // Held step presses: one tick each, STEP_LAT after press
    for (int k = 0; k < 3; k++) begin
      n = cyc;
      h = (k == 0) ? 20 : $urandom_range(8, 20);
      bus.step_btn = 1'b1;
      push(n + STEP_LAT);
      at(n + h);
      bus.step_btn = 1'b0;
      at(cyc + $urandom_range(10, 14));
      chk("step_led", bus.clk_led, npush % 2);
    end

    // Short bounces never produce a tick
    for (int k = 0; k < 3; k++) begin
      w = $urandom_range(1, D - 1);
      bus.step_btn = 1'b1;
      at(cyc + w);
      bus.step_btn = 1'b0;
      at(cyc + 8);
      chk("bounce_led", bus.clk_led, npush % 2);
    end

    // Free-run with rate changes
    enter_run(0);
    more_ticks(3);
    change_rate(2, anchor + $urandom_range(0, cur_p - 1));
    more_ticks(2);
    change_rate(3, anchor + $urandom_range(0, cur_p - 1));
    more_ticks(1);
    change_rate(0, anchor + 20);   // counter already past new P-1
    more_ticks(3);
    for (int k = 0; k < 4; k++) begin
      change_rate($urandom_range(0, 3), anchor + $urandom_range(0, cur_p - 1));
      more_ticks($urandom_range(0, 2));
    end
    // Leave run mode: ticks up to the FSM reaction edge still happen
    c = anchor + $urandom_range(0, cur_p - 1);
    at(c);
    bus.run_sw = 1'b0;
    while (anchor + cur_p <= c + RUN_LAT - 1) begin
      anchor += cur_p;
      push(anchor);
    end
    at(c + RUN_LAT + 1);
    chk("running_off", bus.running, 0);
    chk("run_led", bus.clk_led, npush % 2);

    // Halt coincident with a due tick
    enter_run(0);
    more_ticks(2);
    t = anchor + cur_p;
    at(t - 1);
    bus.cpu_halt = 1'b1;
    at(t);
    bus.cpu_halt = 1'b0;
    chk("halted", bus.halted, 1);
    chk("halt_running", bus.running, 0);
    bus.step_btn = 1'b1; at(cyc + 12); bus.step_btn = 1'b0;
    bus.run_sw = 1'b0;   at(cyc + 12);
    bus.run_sw = 1'b1;   at(cyc + 12);
    bus.run_sw = 1'b0;   at(cyc + 12);
    chk("halt_held", bus.halted, 1);
    chk("halt_led", bus.clk_led, npush % 2);
    c = cyc;
    rst = 1'b1; at(c + 2); rst = 1'b0; npush = 0;
    check_idle("halt_reset");

    // Reset mid-period: fresh debounce and full period afterwards
    enter_run(2);
    more_ticks(1);
    c = anchor + $urandom_range(2, 12);
    at(c);
    rst = 1'b1;
    at(c + 1);
    rst = 1'b0; npush = 0;
    check_idle("midper_reset");
    anchor = c + 1 + RUN_LAT;
    at(anchor);
    chk("rerun", bus.running, 1);
    more_ticks(1);
    at(anchor + 2);
    bus.run_sw = 1'b0;
    at(cyc + RUN_LAT + 2);
    chk("midper_led", bus.clk_led, 1);

    // Reset mid-debounce of a held step press
    n = cyc;
    bus.step_btn = 1'b1;
    at(n + 4);
    rst = 1'b1;
    at(n + 5);
    rst = 1'b0; npush = 0;
    check_idle("middb_reset");
    push(n + 5 + STEP_LAT);
    at(n + 20);
    bus.step_btn = 1'b0;
    at(cyc + 12);
    chk("middb_led", bus.clk_led, 1);

    at(cyc + 40);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
